// File: rtl/video_native_in_port_if.sv
// ============================================================================
// Interface : video_native_in_port_if
// Raw video timing in, gated pixel stream and alignment pulses out.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface video_native_in_port_if #(
    parameter int DSIZE = 24
);
    logic             vsync;
    logic             hsync;
    logic             de;
    logic [DSIZE-1:0] idata;

    logic             falign;
    logic             lalign;
    logic             ealign;
    logic             odata_vld;
    logic [DSIZE-1:0] odata;
    logic             sof;
    logic             eol;

    modport slave (
        input  vsync, hsync, de, idata,
        output falign, lalign, ealign, odata_vld, odata, sof, eol
    );

    modport master (
        output vsync, hsync, de, idata,
        input  falign, lalign, ealign, odata_vld, odata, sof, eol
    );
endinterface

`default_nettype wire

// File: rtl/video_native_in_port.sv
// ============================================================================
// Module : video_native_in_port
// Normalises raw vsync/de, tracks frame/line position and emits a 2-cycle
// delayed pixel stream with alignment and length-error pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module video_native_in_port #(
    parameter int DSIZE  = 24,
    parameter int VS_POL = 1,
    parameter int DE_POL = 1,
    parameter     MODE   = "LINE"
) (
    input  wire logic              clock,
    input  wire logic              rst_n,
    input  wire logic [15:0]       vactive,
    input  wire logic [15:0]       hactive,
    video_native_in_port_if.slave  vid,
    output logic      [15:0]       line_cnt,
    output logic      [15:0]       pix_cnt,
    output logic                   err_hlen,
    output logic                   err_vlen
);

    localparam bit LINE_MODE = (MODE == "LINE");

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        DONE       = 2'd2
    } state_t;

    logic             vs_in;
    logic             de_in;
    logic             unused_hsync;

    logic             s1_vs_q, s1_vs_d;
    logic             s1_de_q, s1_de_d;
    logic [DSIZE-1:0] s1_data_q, s1_data_d;
    logic             s2_vs_q, s2_vs_d;
    logic             s2_de_q, s2_de_d;
    state_t           state_q, state_d;
    logic             falign_q, falign_d;
    logic             lalign_q, lalign_d;
    logic             ealign_q, ealign_d;
    logic             odata_vld_q, odata_vld_d;
    logic [DSIZE-1:0] odata_q, odata_d;
    logic             sof_q, sof_d;
    logic             sof_pend_q, sof_pend_d;
    logic             eol_q, eol_d;
    logic             err_hlen_q, err_hlen_d;
    logic             err_vlen_q, err_vlen_d;
    logic [15:0]      line_cnt_q, line_cnt_d;
    logic [15:0]      pix_cnt_q, pix_cnt_d;

    logic             frame_start;
    logic             line_end;
    logic             in_active;
    logic [15:0]      line_cnt_inc;

    assign vs_in        = (VS_POL != 0) ? vid.vsync : ~vid.vsync;
    assign de_in        = (DE_POL != 0) ? vid.de    : ~vid.de;
    assign unused_hsync = vid.hsync;

    always_comb begin
        frame_start  = s2_vs_q & ~s1_vs_q;
        line_end     = s2_de_q & ~s1_de_q;
        in_active    = (state_q == ACTIVE);
        line_cnt_inc = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;

        s1_vs_d     = vs_in;
        s1_de_d     = de_in;
        s1_data_d   = vid.idata;
        s2_vs_d     = s1_vs_q;
        s2_de_d     = s1_de_q;
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        falign_d    = 1'b0;
        ealign_d    = 1'b0;
        err_hlen_d  = 1'b0;
        lalign_d    = line_end & LINE_MODE;
        odata_vld_d = s1_de_q & in_active;
        odata_d     = s1_data_q;
        // The raw input de closes the line one cycle early, so eol lines up with the last beat.
        eol_d       = s1_de_q & ~de_in & in_active;
        sof_d       = odata_vld_d & sof_pend_q;
        sof_pend_d  = sof_pend_q & ~odata_vld_d;
        err_vlen_d  = line_end & (state_q == DONE);

        pix_cnt_d = pix_cnt_q;
        if (odata_vld_d && pix_cnt_q != 16'hFFFF) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
        end
        if (line_end) begin
            pix_cnt_d = 16'd0;
        end

        // A new frame overrides any line end in the same cycle and drops a partial line.
        if (frame_start) begin
            state_d    = ACTIVE;
            line_cnt_d = 16'd0;
            pix_cnt_d  = 16'd0;
            falign_d   = 1'b1;
            sof_pend_d = 1'b1;
            if (in_active && vactive != 16'd0) begin
                err_vlen_d = 1'b1;
            end
        end else if (line_end && in_active) begin
            line_cnt_d = line_cnt_inc;
            err_hlen_d = (hactive != 16'd0) && (pix_cnt_q != hactive);
            if (vactive != 16'd0 && line_cnt_inc == vactive) begin
                state_d  = DONE;
                ealign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_vs_q     <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_data_q   <= '0;
            s2_vs_q     <= 1'b0;
            s2_de_q     <= 1'b0;
            state_q     <= WAIT_FRAME;
            falign_q    <= 1'b0;
            lalign_q    <= 1'b0;
            ealign_q    <= 1'b0;
            odata_vld_q <= 1'b0;
            odata_q     <= '0;
            sof_q       <= 1'b0;
            sof_pend_q  <= 1'b0;
            eol_q       <= 1'b0;
            err_hlen_q  <= 1'b0;
            err_vlen_q  <= 1'b0;
            line_cnt_q  <= 16'd0;
            pix_cnt_q   <= 16'd0;
        end else begin
            s1_vs_q     <= s1_vs_d;
            s1_de_q     <= s1_de_d;
            s1_data_q   <= s1_data_d;
            s2_vs_q     <= s2_vs_d;
            s2_de_q     <= s2_de_d;
            state_q     <= state_d;
            falign_q    <= falign_d;
            lalign_q    <= lalign_d;
            ealign_q    <= ealign_d;
            odata_vld_q <= odata_vld_d;
            odata_q     <= odata_d;
            sof_q       <= sof_d;
            sof_pend_q  <= sof_pend_d;
            eol_q       <= eol_d;
            err_hlen_q  <= err_hlen_d;
            err_vlen_q  <= err_vlen_d;
            line_cnt_q  <= line_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign vid.falign    = falign_q;
    assign vid.lalign    = lalign_q;
    assign vid.ealign    = ealign_q;
    assign vid.odata_vld = odata_vld_q;
    assign vid.odata     = odata_q;
    assign vid.sof       = sof_q;
    assign vid.eol       = eol_q;
    assign line_cnt      = line_cnt_q;
    assign pix_cnt       = pix_cnt_q;
    assign err_hlen      = err_hlen_q;
    assign err_vlen      = err_vlen_q;

endmodule

`default_nettype wire

// File: tb/tb_video_native_in_port.sv
// ============================================================================
// Module : tb_video_native_in_port
// Drives a default-polarity LINE instance and an inverted-polarity ONCE instance
// with the same frames; beats are scoreboarded, pulses are counted per scenario.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_video_native_in_port;

    localparam int DSIZE = 24;
    localparam int GAP   = 4;

    typedef struct {
        logic [DSIZE-1:0] data;
        int               cyc;
        bit               first;
        bit               last;
    } beat_t;

    typedef struct {
        int falign_a; int lalign_a; int ealign_a; int sof_a; int eol_a;
        int hlen_a;   int vlen_a;   int vld_a;    int vlen_fs_a; int hlen_line_a;
        int falign_b; int lalign_b; int ealign_b; int sof_b; int eol_b;
        int hlen_b;   int vlen_b;   int vld_b;
    } cnt_t;

    logic        clock   = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] vactive = 16'd4;
    logic [15:0] hactive = 16'd8;
    logic [15:0] line_cnt_a, pix_cnt_a, line_cnt_b, pix_cnt_b;
    logic        err_hlen_a, err_vlen_a, err_hlen_b, err_vlen_b;

    int    total      = 0;
    int    bad        = 0;
    int    cyc        = 0;
    bit    first_pend = 1'b0;
    beat_t qa[$];
    beat_t qb[$];
    cnt_t  c;

    video_native_in_port_if #(.DSIZE(DSIZE)) ia ();
    video_native_in_port_if #(.DSIZE(DSIZE)) ib ();

    video_native_in_port #(.DSIZE(DSIZE)) dut_a (
        .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive), .vid(ia),
        .line_cnt(line_cnt_a), .pix_cnt(pix_cnt_a), .err_hlen(err_hlen_a), .err_vlen(err_vlen_a)
    );

    video_native_in_port #(.DSIZE(DSIZE), .VS_POL(0), .DE_POL(0), .MODE("ONCE")) dut_b (
        .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive), .vid(ib),
        .line_cnt(line_cnt_b), .pix_cnt(pix_cnt_b), .err_hlen(err_hlen_b), .err_vlen(err_vlen_b)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit vs, input bit de, input logic [DSIZE-1:0] d);
        ia.vsync = vs;  ia.de = de;  ia.idata = d; ia.hsync = 1'b0;
        ib.vsync = ~vs; ib.de = ~de; ib.idata = d; ib.hsync = 1'b0;
    endtask

    // One clock: inputs are sampled on the rising edge, outputs observed on the falling edge.
    task automatic cycle();
        beat_t e;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        c.falign_a += int'(ia.falign); c.lalign_a += int'(ia.lalign); c.ealign_a += int'(ia.ealign);
        c.sof_a    += int'(ia.sof);    c.eol_a    += int'(ia.eol);
        c.hlen_a   += int'(err_hlen_a); c.vlen_a  += int'(err_vlen_a);
        c.falign_b += int'(ib.falign); c.lalign_b += int'(ib.lalign); c.ealign_b += int'(ib.ealign);
        c.sof_b    += int'(ib.sof);    c.eol_b    += int'(ib.eol);
        c.hlen_b   += int'(err_hlen_b); c.vlen_b  += int'(err_vlen_b);
        if (err_hlen_a === 1'b1) c.hlen_line_a = c.lalign_a;
        if (err_vlen_a === 1'b1 && ia.falign === 1'b1) c.vlen_fs_a++;
        if (ia.ealign === 1'b1) begin
            total++;
            if (ia.lalign !== 1'b1) begin
                bad++;
                $display("FAIL ealign_with_lalign_a: got lalign=%b required 1 at cycle %0d", ia.lalign, cyc);
            end
        end
        if (ia.odata_vld === 1'b1) begin
            c.vld_a++;
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL beat_a: got unexpected odata_vld data=%h at cycle %0d required no beat", ia.odata, cyc);
            end else begin
                e = qa.pop_front();
                if (ia.odata !== e.data || cyc != e.cyc || ia.sof !== e.first || ia.eol !== e.last) begin
                    bad++;
                    $display("FAIL beat_a: got data=%h cyc=%0d sof=%b eol=%b required data=%h cyc=%0d sof=%b eol=%b",
                             ia.odata, cyc, ia.sof, ia.eol, e.data, e.cyc, e.first, e.last);
                end
            end
        end
        if (ib.odata_vld === 1'b1) begin
            c.vld_b++;
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL beat_b: got unexpected odata_vld data=%h at cycle %0d required no beat", ib.odata, cyc);
            end else begin
                e = qb.pop_front();
                if (ib.odata !== e.data || cyc != e.cyc || ib.sof !== e.first || ib.eol !== e.last) begin
                    bad++;
                    $display("FAIL beat_b: got data=%h cyc=%0d sof=%b eol=%b required data=%h cyc=%0d sof=%b eol=%b",
                             ib.odata, cyc, ib.sof, ib.eol, e.data, e.cyc, e.first, e.last);
                end
            end
        end
    endtask

    task automatic vsync_pulse();
        drive(1'b1, 1'b0, '0);
        repeat (2) cycle();
        drive(1'b0, 1'b0, '0);
        repeat (GAP) cycle();
        first_pend = 1'b1;
    endtask

    // Beats driven at cycle n leave the port at cycle n+2.
    task automatic send_line(input int n, input bit expect_out);
        beat_t       b;
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            drive(1'b0, 1'b1, r[DSIZE-1:0]);
            if (expect_out) begin
                b.data  = r[DSIZE-1:0];
                b.cyc   = cyc + 2;
                b.first = first_pend;
                b.last  = (i == n - 1);
                qa.push_back(b);
                qb.push_back(b);
                first_pend = 1'b0;
            end
            cycle();
        end
        drive(1'b0, 1'b0, '0);
        repeat (GAP) cycle();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({ia.falign, ia.lalign, ia.ealign, ia.odata_vld, ia.sof, ia.eol, err_hlen_a, err_vlen_a} !== 8'd0 ||
                line_cnt_a !== 16'd0 || pix_cnt_a !== 16'd0 || ia.odata !== '0) begin
                bad++;
                $display("FAIL reset_outs_a: got line_cnt=%h pix_cnt=%h odata=%h vld=%b required all zero",
                         line_cnt_a, pix_cnt_a, ia.odata, ia.odata_vld);
            end
            total++;
            if ({ib.falign, ib.lalign, ib.ealign, ib.odata_vld, ib.sof, ib.eol, err_hlen_b, err_vlen_b} !== 8'd0 ||
                line_cnt_b !== 16'd0 || pix_cnt_b !== 16'd0 || ib.odata !== '0) begin
                bad++;
                $display("FAIL reset_outs_b: got line_cnt=%h pix_cnt=%h odata=%h vld=%b required all zero",
                         line_cnt_b, pix_cnt_b, ib.odata, ib.odata_vld);
            end
        end
        rst_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_good_frame();
        cnt_t s;
        s = c;
        vactive = 16'd4; hactive = 16'd8;
        vsync_pulse();
        repeat (4) send_line(8, 1'b1);
        total++; if (c.falign_a - s.falign_a != 1) begin bad++; $display("FAIL good_falign_a: got %0d required 1", c.falign_a - s.falign_a); end
        total++; if (c.lalign_a - s.lalign_a != 4) begin bad++; $display("FAIL good_lalign_a: got %0d required 4", c.lalign_a - s.lalign_a); end
        total++; if (c.ealign_a - s.ealign_a != 1) begin bad++; $display("FAIL good_ealign_a: got %0d required 1", c.ealign_a - s.ealign_a); end
        total++; if (c.sof_a - s.sof_a != 1) begin bad++; $display("FAIL good_sof_a: got %0d required 1", c.sof_a - s.sof_a); end
        total++; if (c.eol_a - s.eol_a != 4) begin bad++; $display("FAIL good_eol_a: got %0d required 4", c.eol_a - s.eol_a); end
        total++; if (c.vld_a - s.vld_a != 32) begin bad++; $display("FAIL good_vld_a: got %0d required 32", c.vld_a - s.vld_a); end
        total++;
        if (c.hlen_a - s.hlen_a != 0 || c.vlen_a - s.vlen_a != 0) begin
            bad++; $display("FAIL good_errors_a: got hlen=%0d vlen=%0d required 0 0", c.hlen_a - s.hlen_a, c.vlen_a - s.vlen_a);
        end
        total++; if (line_cnt_a !== 16'd4) begin bad++; $display("FAIL good_line_cnt_a: got %0d required 4", line_cnt_a); end
        total++; if (pix_cnt_a !== 16'd0) begin bad++; $display("FAIL good_pix_cnt_a: got %0d required 0", pix_cnt_a); end
        total++; if (c.lalign_b - s.lalign_b != 0) begin bad++; $display("FAIL once_lalign_b: got %0d required 0", c.lalign_b - s.lalign_b); end
        total++; if (c.ealign_b - s.ealign_b != 1) begin bad++; $display("FAIL once_ealign_b: got %0d required 1", c.ealign_b - s.ealign_b); end
        total++;
        if (c.falign_b - s.falign_b != 1 || c.eol_b - s.eol_b != 4 || c.sof_b - s.sof_b != 1 || line_cnt_b !== 16'd4) begin
            bad++; $display("FAIL once_frame_b: got falign=%0d eol=%0d sof=%0d line_cnt=%0d required 1 4 1 4",
                            c.falign_b - s.falign_b, c.eol_b - s.eol_b, c.sof_b - s.sof_b, line_cnt_b);
        end
    endtask

    task automatic test_short_line();
        cnt_t s;
        s = c;
        vactive = 16'd4; hactive = 16'd8;
        vsync_pulse();
        send_line(8, 1'b1);
        send_line(8, 1'b1);
        send_line(7, 1'b1);
        send_line(8, 1'b1);
        total++; if (c.hlen_a - s.hlen_a != 1) begin bad++; $display("FAIL short_hlen_a: got %0d required 1", c.hlen_a - s.hlen_a); end
        total++; if (c.hlen_line_a != s.lalign_a + 3) begin bad++; $display("FAIL short_hlen_line_a: got line %0d required line 3", c.hlen_line_a - s.lalign_a); end
        total++; if (c.ealign_a - s.ealign_a != 1) begin bad++; $display("FAIL short_ealign_a: got %0d required 1", c.ealign_a - s.ealign_a); end
        total++; if (c.vlen_a - s.vlen_a != 0) begin bad++; $display("FAIL short_vlen_a: got %0d required 0", c.vlen_a - s.vlen_a); end
        total++; if (c.hlen_b - s.hlen_b != 1) begin bad++; $display("FAIL short_hlen_b: got %0d required 1", c.hlen_b - s.hlen_b); end
    endtask

    task automatic test_short_frame();
        cnt_t s;
        s = c;
        vactive = 16'd4; hactive = 16'd8;
        vsync_pulse();
        repeat (3) send_line(8, 1'b1);
        vsync_pulse();
        total++; if (line_cnt_a !== 16'd0) begin bad++; $display("FAIL shortf_line_cnt_a: got %0d required 0", line_cnt_a); end
        total++; if (c.vlen_a - s.vlen_a != 1) begin bad++; $display("FAIL shortf_vlen_a: got %0d required 1", c.vlen_a - s.vlen_a); end
        total++; if (c.vlen_fs_a - s.vlen_fs_a != 1) begin bad++; $display("FAIL shortf_vlen_with_falign_a: got %0d required 1", c.vlen_fs_a - s.vlen_fs_a); end
        total++; if (c.vlen_b - s.vlen_b != 1) begin bad++; $display("FAIL shortf_vlen_b: got %0d required 1", c.vlen_b - s.vlen_b); end
        repeat (4) send_line(8, 1'b1);
        total++; if (c.ealign_a - s.ealign_a != 1) begin bad++; $display("FAIL shortf_ealign_a: got %0d required 1", c.ealign_a - s.ealign_a); end
        total++; if (c.falign_a - s.falign_a != 2) begin bad++; $display("FAIL shortf_falign_a: got %0d required 2", c.falign_a - s.falign_a); end
    endtask

    task automatic test_extra_line();
        cnt_t s;
        s = c;
        vactive = 16'd2; hactive = 16'd8;
        vsync_pulse();
        send_line(8, 1'b1);
        send_line(8, 1'b1);
        send_line(8, 1'b0);
        total++; if (c.ealign_a - s.ealign_a != 1) begin bad++; $display("FAIL extra_ealign_a: got %0d required 1", c.ealign_a - s.ealign_a); end
        total++; if (c.vlen_a - s.vlen_a != 1) begin bad++; $display("FAIL extra_vlen_a: got %0d required 1", c.vlen_a - s.vlen_a); end
        total++; if (c.vld_a - s.vld_a != 16) begin bad++; $display("FAIL extra_vld_a: got %0d required 16", c.vld_a - s.vld_a); end
        total++; if (c.lalign_a - s.lalign_a != 3) begin bad++; $display("FAIL extra_lalign_a: got %0d required 3", c.lalign_a - s.lalign_a); end
        total++; if (c.eol_a - s.eol_a != 2) begin bad++; $display("FAIL extra_eol_a: got %0d required 2", c.eol_a - s.eol_a); end
        total++; if (line_cnt_a !== 16'd2) begin bad++; $display("FAIL extra_line_cnt_a: got %0d required 2", line_cnt_a); end
        total++; if (c.vlen_b - s.vlen_b != 1 || c.vld_b - s.vld_b != 16) begin
            bad++; $display("FAIL extra_b: got vlen=%0d vld=%0d required 1 16", c.vlen_b - s.vlen_b, c.vld_b - s.vld_b);
        end
    endtask

    task automatic test_reset_midline();
        cnt_t        s;
        logic [31:0] r;
        vactive = 16'd4; hactive = 16'd8;
        vsync_pulse();
        for (int i = 0; i < 6; i++) begin
            send_beat_only();
        end
        // Beats still inside the pipeline are discarded by the reset.
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            drive(1'b0, 1'b1, r[DSIZE-1:0]);
            cycle();
            total++;
            if ({ia.falign, ia.lalign, ia.ealign, ia.odata_vld, ia.sof, ia.eol, err_hlen_a, err_vlen_a} !== 8'd0 ||
                line_cnt_a !== 16'd0 || pix_cnt_a !== 16'd0 || ia.odata !== '0) begin
                bad++;
                $display("FAIL midreset_outs_a: got line_cnt=%h pix_cnt=%h odata=%h vld=%b required all zero",
                         line_cnt_a, pix_cnt_a, ia.odata, ia.odata_vld);
            end
            total++;
            if ({ib.falign, ib.lalign, ib.ealign, ib.odata_vld, ib.sof, ib.eol, err_hlen_b, err_vlen_b} !== 8'd0 ||
                line_cnt_b !== 16'd0 || pix_cnt_b !== 16'd0 || ib.odata !== '0) begin
                bad++;
                $display("FAIL midreset_outs_b: got line_cnt=%h pix_cnt=%h odata=%h vld=%b required all zero",
                         line_cnt_b, pix_cnt_b, ib.odata, ib.odata_vld);
            end
        end
        s = c;
        rst_n = 1'b1;
        send_line(5, 1'b0);
        send_line(6, 1'b0);
        total++; if (c.vld_a - s.vld_a != 0 || c.vld_b - s.vld_b != 0) begin
            bad++; $display("FAIL postreset_vld: got a=%0d b=%0d required 0 0", c.vld_a - s.vld_a, c.vld_b - s.vld_b);
        end
        total++; if (c.hlen_a - s.hlen_a != 0 || c.vlen_a - s.vlen_a != 0 || c.falign_a - s.falign_a != 0) begin
            bad++; $display("FAIL postreset_events_a: got hlen=%0d vlen=%0d falign=%0d required 0 0 0",
                            c.hlen_a - s.hlen_a, c.vlen_a - s.vlen_a, c.falign_a - s.falign_a);
        end
        total++; if (line_cnt_a !== 16'd0) begin bad++; $display("FAIL postreset_line_cnt_a: got %0d required 0", line_cnt_a); end
    endtask

    task automatic send_beat_only();
        beat_t       b;
        logic [31:0] r;
        r = $urandom;
        drive(1'b0, 1'b1, r[DSIZE-1:0]);
        b.data  = r[DSIZE-1:0];
        b.cyc   = cyc + 2;
        b.first = first_pend;
        b.last  = 1'b0;
        qa.push_back(b);
        qb.push_back(b);
        first_pend = 1'b0;
        cycle();
    endtask

    task automatic test_checks_disabled();
        cnt_t s;
        s = c;
        vactive = 16'd0; hactive = 16'd0;
        vsync_pulse();
        send_line(5, 1'b1);
        send_line(3, 1'b1);
        total++; if (c.lalign_a - s.lalign_a != 2) begin bad++; $display("FAIL nochk_lalign_a: got %0d required 2", c.lalign_a - s.lalign_a); end
        total++; if (line_cnt_a !== 16'd2) begin bad++; $display("FAIL nochk_line_cnt_a: got %0d required 2", line_cnt_a); end
        total++; if (c.ealign_a - s.ealign_a != 0 || c.hlen_a - s.hlen_a != 0 || c.vlen_a - s.vlen_a != 0) begin
            bad++; $display("FAIL nochk_events_a: got ealign=%0d hlen=%0d vlen=%0d required 0 0 0",
                            c.ealign_a - s.ealign_a, c.hlen_a - s.hlen_a, c.vlen_a - s.vlen_a);
        end
        total++; if (c.sof_a - s.sof_a != 1 || c.eol_a - s.eol_a != 2) begin
            bad++; $display("FAIL nochk_sof_eol_a: got sof=%0d eol=%0d required 1 2", c.sof_a - s.sof_a, c.eol_a - s.eol_a);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, '0);
        test_reset();
        test_good_frame();
        test_short_line();
        test_short_frame();
        test_extra_line();
        test_reset_midline();
        test_checks_disabled();
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got pending a=%0d b=%0d required 0 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
